div_32: RTL and testbench



---
 rtl/div_32.sv | 162 ++++++++++++++++
 tb/tb_div_32.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_32.sv
// div_32: restoring shift-subtract divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement signed division.
module div_32 (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ADJ
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic [31:0] b_q, b_d;
    logic [31:0] a_q, a_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        dz_q, dz_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        done_q, done_d;
    logic        dzo_q, dzo_d;
`ifdef DIV_SIGNED_EN
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
`endif

    logic [32:0] r_sh;
    logic [32:0] t;
    logic [31:0] mag_a, mag_b;
    logic [31:0] q_fin, r_fin;

    always_comb begin
        r_sh = {r_q, q_q[31]};
        t    = r_sh + ~{1'b0, b_q} + 33'd1;
`ifdef DIV_SIGNED_EN
        mag_a = dividend[31] ? -dividend : dividend;
        mag_b = divisor[31]  ? -divisor  : divisor;
        q_fin = (sa_q ^ sb_q) ? -q_q : q_q;
        // remainder follows the sign of the dividend
        r_fin = sa_q ? -r_q : r_q;
`else
        mag_a = dividend;
        mag_b = divisor;
        q_fin = q_q;
        r_fin = r_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        b_d     = b_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dzo_d   = dzo_q;
`ifdef DIV_SIGNED_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    a_d     = dividend;
                    q_d     = mag_a;
                    b_d     = mag_b;
                    dz_d    = (divisor == 32'd0);
                    r_d     = 32'd0;
                    cnt_d   = 5'd0;
`ifdef DIV_SIGNED_EN
                    sa_d    = dividend[31];
                    sb_d    = divisor[31];
`endif
                end
            end
            CALC: begin
                // a clear borrow means the shifted remainder covers the divisor
                r_d   = t[32] ? r_sh[31:0] : t[31:0];
                q_d   = {q_q[30:0], ~t[32]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ADJ;
                end
            end
            ADJ: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dzo_d   = dz_q;
                quot_d  = dz_q ? 32'hFFFF_FFFF : q_fin;
                rem_d   = dz_q ? a_q : r_fin;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_q    <= 32'd0;
            q_q    <= 32'd0;
            b_q    <= 32'd0;
            a_q    <= 32'd0;
            cnt_q  <= 5'd0;
            dz_q   <= 1'b0;
            quot_q <= 32'd0;
            rem_q  <= 32'd0;
            done_q <= 1'b0;
            dzo_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
`endif
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            b_q    <= b_d;
            a_q    <= a_d;
            cnt_q  <= cnt_d;
            dz_q   <= dz_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            done_q <= done_d;
            dzo_q  <= dzo_d;
`ifdef DIV_SIGNED_EN
            sa_q   <= sa_d;
            sb_q   <= sb_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dzo_q;

endmodule

// File: tb/tb_div_32.sv
// tb_div_32: random and directed checks of div_32 against a
// bench-side arithmetic model of quotient/remainder/timing.
module tb_div_32;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    div_32 dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
        int sa;
        int sb;
        sa = a;
        sb = b;
        dz = (b == 32'd0);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end
`ifdef DIV_SIGNED_EN
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
`else
        else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction

    // Timing model: a request accepted when idle completes 33 edges later.
    int          cnt = 0;
    logic        edone = 1'b0;
    logic [31:0] eq = 32'd0;
    logic [31:0] er = 32'd0;
    logic        edz = 1'b0;
    logic [31:0] pq = 32'd0;
    logic [31:0] pr = 32'd0;
    logic        pdz = 1'b0;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt = 0;
            edone = 1'b0;
            eq = 32'd0;
            er = 32'd0;
            edz = 1'b0;
        end else begin
            edone = 1'b0;
            if (cnt == 0) begin
                if (start) begin
                    model(dividend, divisor, pq, pr, pdz);
                    cnt = 33;
                end
            end else begin
                cnt--;
                if (cnt == 0) begin
                    edone = 1'b1;
                    eq = pq;
                    er = pr;
                    edz = pdz;
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("busy", busy, (cnt != 0));
        chk("done", done, edone);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_zero", div_zero, edz);
    end

    task automatic wait_done(output int n, output int bcnt);
        n = 0;
        bcnt = 0;
        forever begin
            @(negedge clock);
            n++;
            if (busy) bcnt++;
            if (done) break;
            if (n > 60) begin
                checks++;
                $display("FAIL done_timeout: got no done want done within 34");
                break;
            end
        end
    endtask

    // Returns at the falling edge of the done cycle, so a following
    // call raises start in the done cycle (back-to-back).
    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output int clks, output int bcnt);
        int n;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        chk("accept", busy, 1'b1);
        wait_done(n, bcnt);
        clks = n - 1;
        q = quotient;
        r = remainder;
        dz = div_zero;
    endtask

    logic [31:0] q, r, a, b;
    logic        dz;
    int          clks, bcnt, seen, n;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_div_zero", div_zero, 1'b0);
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock);
        #1;

        run(32'd100, 32'd7, q, r, dz, clks, bcnt);
        chk("d100_7_q", q, 32'd14);
        chk("d100_7_r", r, 32'd2);
        chk("d100_7_dz", dz, 1'b0);
        chk("d100_7_latency", clks, 33);
        chk("d100_7_busy_cycles", bcnt, 33);

        run(32'd5, 32'd0, q, r, dz, clks, bcnt);
        chk("b2b_latency", clks, 33);
        chk("d5_0_q", q, 32'hFFFF_FFFF);
        chk("d5_0_r", r, 32'd5);
        chk("d5_0_dz", dz, 1'b1);
        run(32'd9, 32'd3, q, r, dz, clks, bcnt);
        chk("d9_3_q", q, 32'd3);
        chk("d9_3_r", r, 32'd0);
        chk("d9_3_dz", dz, 1'b0);

`ifdef DIV_SIGNED_EN
        run(32'hFFFF_FF9C, 32'd7, q, r, dz, clks, bcnt);
        chk("dm100_7_q", q, 32'hFFFF_FFF2);
        chk("dm100_7_r", r, 32'hFFFF_FFFE);
        run(32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, clks, bcnt);
        chk("dmin_m1_q", q, 32'h8000_0000);
        chk("dmin_m1_r", r, 32'd0);
`else
        run(32'hFFFF_FFF2, 32'd7, q, r, dz, clks, bcnt);
        chk("dbig_7_q", q, 32'h2492_4922);
        chk("dbig_7_r", r, 32'd4);
`endif

        // start while busy is ignored
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        dividend = 32'd77;
        divisor = 32'd7;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(n, bcnt);
        chk("ignore_q", quotient, 32'd10);
        chk("ignore_r", remainder, 32'd0);

        // reset mid-division
        @(posedge clock);
        #1;
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        clear_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_q", quotient, 32'd0);
        chk("abort_r", remainder, 32'd0);
        chk("abort_done", done, 1'b0);
        chk("abort_dz", div_zero, 1'b0);
        @(negedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                3: b = b >> $urandom_range(0, 31);
                4: a = a >> $urandom_range(0, 31);
                default: ;
            endcase
            run(a, b, q, r, dz, clks, bcnt);
            chk("rand_latency", clks, 33);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
